caravel_wb_mem_bridge: RTL

Wishbone-classic slave that lets the Caravel management core read and write SoC main memory (24 kB SRAM) through the caravel_wbs_* port of the soc. Sits directly downstream of the soc's Caravel Wishbone interface and upstream of the memory arbiter, where it competes with the RV32I core's data port. Decodes the user-area address window, converts byte addresses to word requests, and waits on arbiter grant and read return. Generates a single-cycle ack for every accepted cycle.

---
 rtl/caravel_wb_mem_bridge.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/caravel_wb_mem_bridge.sv
// Wishbone-classic slave giving the Caravel management core word access to SoC SRAM via the memory arbiter.
// Define CARAVEL_WB_TIMEOUT_EN to add a grant/read-return watchdog and the sticky timeout_o flag.
module caravel_wb_mem_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned MEM_BYTES      = 24576,
  parameter int unsigned ADDR_W         = 13,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              oob_o
`ifdef CARAVEL_WB_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q;
  logic              ack_q;
  logic              oob_q, oob_d;

  // Window decode: addresses below BASE_ADDR wrap to huge offsets and fall out of window.
  logic [31:0] adr_off;
  logic        in_win;
  logic        unused_adr_bits;

  assign adr_off         = wbs_adr_i - BASE_ADDR;
  assign in_win          = (adr_off < 32'(MEM_BYTES));
  assign unused_adr_bits = ^{adr_off[1:0], adr_off[31:ADDR_W+2]};

`ifdef CARAVEL_WB_TIMEOUT_EN
  localparam int unsigned WDOG_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hBADC_0DE0;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_hit;
  logic              tmo_q, tmo_d;
  logic              drain_q, drain_d;

  assign wdog_hit = (wdog_q == WDOG_LAST);
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    oob_d   = oob_q;
`ifdef CARAVEL_WB_TIMEOUT_EN
    wdog_d  = '0;
    tmo_d   = tmo_q;
    drain_d = drain_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_d    = wbs_we_i;
          be_d    = wbs_sel_i;
          addr_d  = adr_off[ADDR_W+1:2];
          wdata_d = wbs_dat_i;
          if (!in_win) begin
            state_d = ACK;
            oob_d   = 1'b1;
          end else if (wbs_sel_i == 4'h0) begin
            state_d = ACK;
          end else begin
            state_d = REQ;
          end
        end
      end

      REQ: begin
        // A grant commits the access even if the master has just abandoned the cycle.
        if (mem_gnt_i) begin
          if (!wbs_cyc_i) begin
            state_d = we_q ? IDLE : DRAIN;
          end else begin
            state_d = we_q ? ACK : WAIT;
          end
        end else if (!wbs_cyc_i) begin
          state_d = IDLE;
`ifdef CARAVEL_WB_TIMEOUT_EN
        end else if (wdog_hit) begin
          state_d = ACK;
          rdata_d = TIMEOUT_DATA;
          tmo_d   = 1'b1;
`endif
        end
      end

      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          state_d = ACK;
          rdata_d = mem_rdata_i;
`ifdef CARAVEL_WB_TIMEOUT_EN
        end else if (wdog_hit) begin
          state_d = ACK;
          rdata_d = TIMEOUT_DATA;
          tmo_d   = 1'b1;
          drain_d = 1'b1;
`endif
        end
      end

      ACK: begin
`ifdef CARAVEL_WB_TIMEOUT_EN
        state_d = drain_q ? DRAIN : IDLE;
        drain_d = 1'b0;
`else
        state_d = IDLE;
`endif
      end

      DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef CARAVEL_WB_TIMEOUT_EN
    // Watchdog restarts on every state change and only counts while waiting on the arbiter.
    if (((state_q == REQ) || (state_q == WAIT)) && (state_d == state_q)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      req_q   <= (state_d == REQ);
      ack_q   <= (state_d == ACK);
      oob_q   <= oob_d;
    end
  end

`ifdef CARAVEL_WB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
      drain_q <= drain_d;
    end
  end

  assign timeout_o = tmo_q;
`endif

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign oob_o       = oob_q;

endmodule
